// File: rtl/fibonacci_checker_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : fibonacci_checker_if
// Brief    : Beat-offer / result bundle for the Fibonacci sequence checker.
// Revision : 1.0 - initial release
// ============================================================================
interface fibonacci_checker_if;
    logic        in_valid;
    logic        in_two;
    logic [15:0] in_num;
    logic [15:0] in_num2;
    logic        in_ready;
    logic        match;
    logic        error;
    logic [7:0]  count;

    modport master (
        output in_valid, in_two, in_num, in_num2,
        input  in_ready, match, error, count
    );

    modport slave (
        input  in_valid, in_two, in_num, in_num2,
        output in_ready, match, error, count
    );
endinterface
`default_nettype wire

// File: rtl/fibonacci_checker.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : fibonacci_checker
// Brief    : Checks a stream of 1- or 2-term beats against the Fibonacci
//            recurrence (mod 2^16). Define FIB_CHECK_SEED_EN to require the
//            first two terms to be 1, 1.
// Revision : 1.0 - initial release
// ============================================================================
module fibonacci_checker (
    input  wire logic          clk,
    input  wire logic          rst_n,
    input  wire logic          clear,
    fibonacci_checker_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ONE  = 2'd1,
        RUN  = 2'd2,
        ERR  = 2'd3
    } state_t;

    localparam logic [7:0]  C_COUNT_MAX = 8'd255;
    localparam logic [15:0] C_SEED      = 16'd1;

    state_t      r_state;
    logic [15:0] r_h0;
    logic [15:0] r_h1;
    logic        r_in_ready;
    logic        r_match;
    logic        r_error;
    logic [7:0]  r_count;

    logic        w_accept;
    logic        w_ok;
    logic        w_seed1_ok;
    logic        w_seed2_ok;
    logic [15:0] w_sum_hist;
    logic [15:0] w_sum_newer;
    state_t      w_next_state;
    logic [15:0] w_next_h0;
    logic [15:0] w_next_h1;
    logic [8:0]  w_count_sum;
    logic [7:0]  w_count_next;

    assign w_accept    = bus.in_valid & r_in_ready;
    assign w_sum_hist  = r_h0 + r_h1;
    assign w_sum_newer = r_h1 + bus.in_num;

`ifdef FIB_CHECK_SEED_EN
    assign w_seed1_ok = (bus.in_num  == C_SEED);
    assign w_seed2_ok = (bus.in_num2 == C_SEED);
`else
    assign w_seed1_ok = 1'b1;
    assign w_seed2_ok = 1'b1;
`endif

    // Per-state verdict and the history that a passing beat leaves behind.
    always_comb begin
        w_ok         = 1'b0;
        w_next_state = r_state;
        w_next_h0    = r_h0;
        w_next_h1    = r_h1;
        case (r_state)
            IDLE: begin
                if (bus.in_two) begin
                    w_ok         = w_seed1_ok & w_seed2_ok;
                    w_next_state = RUN;
                    w_next_h0    = bus.in_num;
                    w_next_h1    = bus.in_num2;
                end else begin
                    w_ok         = w_seed1_ok;
                    w_next_state = ONE;
                    w_next_h1    = bus.in_num;
                end
            end
            ONE: begin
                w_next_state = RUN;
                if (bus.in_two) begin
                    w_ok      = w_seed1_ok & (bus.in_num2 == w_sum_newer);
                    w_next_h0 = bus.in_num;
                    w_next_h1 = bus.in_num2;
                end else begin
                    w_ok      = w_seed1_ok;
                    w_next_h0 = r_h1;
                    w_next_h1 = bus.in_num;
                end
            end
            RUN: begin
                w_next_state = RUN;
                if (bus.in_two) begin
                    w_ok      = (bus.in_num == w_sum_hist) &&
                                (bus.in_num2 == w_sum_newer);
                    w_next_h0 = bus.in_num;
                    w_next_h1 = bus.in_num2;
                end else begin
                    w_ok      = (bus.in_num == w_sum_hist);
                    w_next_h0 = r_h1;
                    w_next_h1 = bus.in_num;
                end
            end
            default: begin
                w_ok         = 1'b0;
                w_next_state = ERR;
            end
        endcase
    end

    assign w_count_sum  = {1'b0, r_count} + (bus.in_two ? 9'd2 : 9'd1);
    assign w_count_next = w_count_sum[8] ? C_COUNT_MAX : w_count_sum[7:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_h0       <= '0;
            r_h1       <= '0;
            r_in_ready <= 1'b1;
            r_match    <= 1'b0;
            r_error    <= 1'b0;
            r_count    <= '0;
        end else if (clear) begin
            r_state    <= IDLE;
            r_h0       <= '0;
            r_h1       <= '0;
            r_in_ready <= 1'b1;
            r_match    <= 1'b0;
            r_error    <= 1'b0;
            r_count    <= '0;
        end else begin
            r_match <= 1'b0;
            if (w_accept) begin
                if (w_ok) begin
                    r_state <= w_next_state;
                    r_h0    <= w_next_h0;
                    r_h1    <= w_next_h1;
                    r_count <= w_count_next;
                    r_match <= 1'b1;
                end else begin
                    // ERR blocks further beats until clear or reset.
                    r_state    <= ERR;
                    r_in_ready <= 1'b0;
                    r_error    <= 1'b1;
                end
            end
        end
    end

    assign bus.in_ready = r_in_ready;
    assign bus.match    = r_match;
    assign bus.error    = r_error;
    assign bus.count    = r_count;

endmodule
`default_nettype wire
